flt2int: RTL and testbench
==========================

Name: flt2int

Overview:
- Converts one IEEE-754 half-precision value in data memory to a 16-bit two's-complement integer, and writes the result back to data memory.
- Hardware partner of the int-to-float conversion. It follows the same testbench handshake: reset / start / done.
- Owns the data_mem port and does all memory access through that port; no hierarchical pokes.
- Multicycle FSM with an iterative 1-bit-per-cycle shifter.

Parameters:
- SRC_ADDR, 8'd4: address of the input float. Low byte is at SRC_ADDR, high byte at SRC_ADDR+1.
- DST_ADDR, 8'd6: address of the result. Low byte is at DST_ADDR, high byte at DST_ADDR+1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high master reset.
- start  in  1  request. Held high ≥1 cycle; conversion runs after it falls.
- done  out  1  acknowledge. High when the result is in memory.
- DataAddress  out  8  data_mem address.
- ReadMem  out  1  read strobe.
- WriteMem  out  1  write enable; memory writes DataIn at the next posedge.
- DataIn  out  8  write data to data_mem.
- DataOut  in  8  read data from data_mem. Combinational: valid in the same cycle as DataAddress.

Behaviour:
- One clock, clk. reset is synchronous and active-high; it is sampled only on posedge clk.
- Reset values:
  - State = IDLE.
  - done = 0, WriteMem = 0, ReadMem = 0, DataAddress = 0, DataIn = 0.
  - Internal registers cleared.
- Priority: reset > start > FSM progress.
- start = 1 in any state: the FSM goes to or stays in ARM, and done = 0. Reasserting start mid-conversion aborts and restarts the conversion; no write is issued after the abort.
- States and transitions:
  - IDLE → ARM on start.
  - ARM → RD_LO when start = 0.
  - RD_LO: DataAddress = SRC_ADDR, ReadMem = 1; capture the low byte.
  - RD_HI: DataAddress = SRC_ADDR+1; capture the high byte.
  - DECODE: split into s = f[15], e = f[14:10], m = f[9:0]; sig = {1, m} (11 bits). Then:
    - e = 0 (zero or subnormal) → mag = 0, go to NEG.
    - e = 31, or e ≥ 30 with a result that does not fit → saturate, go to NEG.
    - e ≤ 13 → mag = 0, go to NEG.
    - Otherwise load the shift count: cnt = e − 25. Positive means left shift; negative means right shift.
  - SHIFT: one bit per cycle, cnt moves toward 0.
    - Right shift: guard ← the bit shifted out; sticky |= the old guard.
    - Left shift: shift in zeros.
    - cnt = 0 → ROUND.
  - ROUND: round-to-nearest-even. Increment mag if guard & (sticky | mag[0]).
  - NEG:
    - Result = s ? −mag : mag.
    - Saturation: positive with mag ≥ 32768 → 16'h7FFF. Negative with mag > 32768 → 16'h8000. Negative with mag = 32768 → 16'h8000 (exact).
  - WR_LO: WriteMem = 1, DataAddress = DST_ADDR, DataIn = res[7:0].
  - WR_HI: WriteMem = 1, DataAddress = DST_ADDR+1, DataIn = res[15:8].
  - DONE: done = 1, held until the next start or reset. WriteMem = 0.
- Widths: mag is 17 bits internally so overflow is detectable. Left shift ≤ 5; right shift ≤ 11.
- Latency: done rises ≤ 20 cycles after the first cycle with start = 0. The worst case is e = 14 (11 shifts).
- Outside RD/WR states, ReadMem = WriteMem = 0. No memory access occurs in IDLE, ARM or DONE.
- −0 (16'h8000) → 16'h0000.

Optional Feature:
- Macro: FLT2INT_RNE_EN.
- Defined: the ROUND state performs round-to-nearest-even as described above.
- Undefined: ROUND passes mag through unchanged, i.e. truncation toward zero. guard and sticky are ignored.
- Saturation behaviour is identical in both builds.

Test Plan:
- mem[5:4] = 16'h3C00 (1.0), pulse start → mem[7:6] = 16'h0001, done = 1 within 20 cycles.
- mem[5:4] = 16'hC500 (−5.0) → mem[7:6] = 16'hFFFB. With mem = 16'h77FF → mem[7:6] = 16'h7FF0 (32752).
- Rounding:
  - 16'h3800 (0.5) → 16'h0000.
  - 16'h3E00 (1.5) → 16'h0002 with FLT2INT_RNE_EN, 16'h0001 without.
  - 16'h4100 (2.5) → 16'h0002 in both builds.
- Saturation:
  - 16'h7800 (+32768) → 16'h7FFF.
  - 16'hF800 (−32768) → 16'h8000.
  - 16'h7C00 (+inf) → 16'h7FFF.
  - 16'h0001 (subnormal) → 16'h0000.
- Reassert start 3 cycles into a conversion of 16'h3C00, after changing mem[5:4] to 16'h4500 → single write of 16'h0005 only; done low until then.
- Assert reset while in SHIFT → the next posedge gives done = 0, WriteMem = 0, no writes. A following start/convert of 16'h3C00 works normally.

Source files
------------

// File: rtl/flt2int.sv
// Half-precision float to 16-bit signed integer converter, memory mapped via data_mem.
// Define FLT2INT_RNE_EN for round-to-nearest-even; otherwise ROUND truncates toward zero.
module flt2int #(
  parameter logic [7:0] SRC_ADDR = 8'd4,
  parameter logic [7:0] DST_ADDR = 8'd6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] DataAddress,
  output logic       ReadMem,
  output logic       WriteMem,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut
);

  typedef enum logic [3:0] {
    StIdle, StArm, StRdLo, StRdHi, StDecode, StShift, StRound, StNeg, StWrLo, StWrHi, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        f_q, f_d;
  logic [16:0]        mag_q, mag_d;
  logic signed [4:0]  cnt_q, cnt_d;
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
  logic [15:0]        res_q, res_d;

  logic [4:0]  exp_f;
  logic [10:0] sig;
  logic        to_neg;

  assign exp_f  = f_q[14:10];
  assign sig    = {1'b1, f_q[9:0]};
  // Zero, subnormal, |x| < 0.5, or beyond int16 range: no shifting needed.
  assign to_neg = (exp_f <= 5'd13) || (exp_f >= 5'd30);

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StArm;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StIdle;
        StArm:    state_d = StRdLo;
        StRdLo:   state_d = StRdHi;
        StRdHi:   state_d = StDecode;
        StDecode: begin
          if (to_neg)                  state_d = StNeg;
          else if (exp_f == 5'd25)     state_d = StRound;
          else                         state_d = StShift;
        end
        StShift:  begin
          if ((cnt_q == 5'sd1) || (cnt_q == -5'sd1)) state_d = StRound;
        end
        StRound:  state_d = StNeg;
        StNeg:    state_d = StWrLo;
        StWrLo:   state_d = StWrHi;
        StWrHi:   state_d = StDone;
        StDone:   state_d = StDone;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    done        = 1'b0;
    DataAddress = 8'd0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    DataIn      = 8'd0;
    unique case (state_q)
      StRdLo: begin
        DataAddress = SRC_ADDR;
        ReadMem     = 1'b1;
      end
      StRdHi: begin
        DataAddress = SRC_ADDR + 8'd1;
        ReadMem     = 1'b1;
      end
      // An abort request suppresses the write in the same cycle.
      StWrLo: begin
        DataAddress = DST_ADDR;
        WriteMem    = ~start;
        DataIn      = res_q[7:0];
      end
      StWrHi: begin
        DataAddress = DST_ADDR + 8'd1;
        WriteMem    = ~start;
        DataIn      = res_q[15:8];
      end
      StDone:  done = ~start;
      default: ;
    endcase
  end

  always_comb begin
    f_d      = f_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    res_d    = res_q;
    unique case (state_q)
      StRdLo: f_d[7:0]  = DataOut;
      StRdHi: f_d[15:8] = DataOut;
      StDecode: begin
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        cnt_d    = 5'sd0;
        if (exp_f <= 5'd13) begin
          mag_d = 17'd0;
        end else if (exp_f >= 5'd30) begin
          mag_d = 17'h1_FFFF;
        end else begin
          mag_d = {6'd0, sig};
          cnt_d = $signed(exp_f - 5'd25);
        end
      end
      StShift: begin
        if (!cnt_q[4]) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - 5'sd1;
        end else begin
          mag_d    = mag_q >> 1;
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
          cnt_d    = cnt_q + 5'sd1;
        end
      end
      StRound: begin
`ifdef FLT2INT_RNE_EN
        if (guard_q && (sticky_q || mag_q[0])) mag_d = mag_q + 17'd1;
`else
        mag_d = mag_q;
`endif
      end
      StNeg: begin
        if (!f_q[15]) res_d = (mag_q >= 17'd32768) ? 16'h7FFF : mag_q[15:0];
        else          res_d = (mag_q >= 17'd32768) ? 16'h8000 : 16'd0 - mag_q[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q      <= 16'd0;
      mag_q    <= 17'd0;
      cnt_q    <= 5'sd0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      res_q    <= 16'd0;
    end else begin
      f_q      <= f_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      res_q    <= res_d;
    end
  end

endmodule

// File: tb/tb_flt2int.sv
// Directed self-checking bench for flt2int with a behavioural data memory.
module tb_flt2int;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] DataAddress;
  logic       ReadMem;
  logic       WriteMem;
  logic [7:0] DataIn;
  logic [7:0] DataOut;

  logic [7:0] mem [256];
  logic       load_en;
  logic [7:0] load_addr;
  logic [7:0] load_data;
  int         wr_count = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  flt2int dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .DataAddress (DataAddress),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .DataIn      (DataIn),
    .DataOut     (DataOut)
  );

  assign DataOut = mem[DataAddress];

  always @(posedge clk) begin
    if (WriteMem) begin
      mem[DataAddress] <= DataIn;
      wr_count <= wr_count + 1;
    end else if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load16(input logic [7:0] addr, input logic [15:0] val);
    load_en = 1'b1; load_addr = addr;        load_data = val[7:0];  tick();
    load_addr = addr + 8'd1; load_data = val[15:8]; tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick();
    start = 1'b0;
  endtask

  // Waits for done, returning the cycle count since start fell (0 on timeout).
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [15:0] f, input logic [15:0] exp);
    int n;
    int w0;
    load16(8'd6, 16'hAAAA);
    load16(8'd4, f);
    w0 = wr_count;
    pulse_start();
    wait_done(n);
    check({tag, "_lat"}, (n >= 1 && n <= 20), 1);
    check({tag, "_res"}, {mem[7], mem[6]}, exp);
    check({tag, "_wr"}, wr_count - w0, 2);
  endtask

  initial begin
    int n;
    int w0;
    logic [15:0] exp_1p5;
    logic [15:0] exp_2p75;
`ifdef FLT2INT_RNE_EN
    exp_1p5  = 16'h0002;
    exp_2p75 = 16'h0003;
`else
    exp_1p5  = 16'h0001;
    exp_2p75 = 16'h0002;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = 8'd0; load_data = 8'd0;
    tick(); tick();
    check("rst_done", done, 0);
    check("rst_wr", WriteMem, 0);
    check("rst_rd", ReadMem, 0);
    check("rst_addr", DataAddress, 0);
    check("rst_din", DataIn, 0);
    reset = 1'b0;
    tick();
    check("idle_done", done, 0);

    run("one",      16'h3C00, 16'h0001);
    check("done_hold", done, 1);
    run("neg5",     16'hC500, 16'hFFFB);
    run("max_fit",  16'h77FF, 16'h7FF0);
    run("half",     16'h3800, 16'h0000);
    run("one_half", 16'h3E00, exp_1p5);
    run("two_half", 16'h4100, 16'h0002);
    run("two_3q",   16'h4180, exp_2p75);
    run("e25",      16'h6401, 16'h0401);
    run("pos_sat",  16'h7800, 16'h7FFF);
    run("neg_sat",  16'hF800, 16'h8000);
    run("pos_inf",  16'h7C00, 16'h7FFF);
    run("neg_inf",  16'hFC00, 16'h8000);
    run("subnorm",  16'h0001, 16'h0000);
    run("neg_zero", 16'h8000, 16'h0000);

    // Abort: restart mid-conversion with a new source value.
    load16(8'd6, 16'hAAAA);
    load16(8'd4, 16'h3C00);
    w0 = wr_count;
    pulse_start();
    tick(); tick();
    load16(8'd4, 16'h4500);
    check("abort_done_lo", done, 0);
    pulse_start();
    wait_done(n);
    check("abort_lat", (n >= 1 && n <= 20), 1);
    check("abort_wr", wr_count - w0, 2);
    check("abort_res", {mem[7], mem[6]}, 16'h0005);

    // Reset while shifting suppresses all writes.
    load16(8'd6, 16'hAAAA);
    load16(8'd4, 16'h3800);
    w0 = wr_count;
    pulse_start();
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check("rst_shift_done", done, 0);
    check("rst_shift_wr", WriteMem, 0);
    reset = 1'b0;
    repeat (25) tick();
    check("rst_shift_nowr", wr_count - w0, 0);
    check("rst_shift_idle", done, 0);
    check("rst_shift_mem", {mem[7], mem[6]}, 16'hAAAA);
    run("after_rst", 16'h3C00, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
